// File: rtl/mem_pkg.sv
// Shared memory-path definitions: egress word format and the ingress arbiter
// state encoding.
package mem_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int LAST_BIT   = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRES = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: returns the first requester strictly above
// i_last, wrapping around, as both a one-hot vector and an index.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = 0;
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(i_last) + k) % N;
      if (!o_any && i_req[w_cand]) begin
        o_any            = 1'b1;
        o_idx            = IW'(w_cand);
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ingress_frame_arbiter.sv
// Frame-granular round-robin arbiter draining N ingress FIFOs onto a single
// valid/ready egress stream, with a per-frame word limit that forces truncation.
module ingress_frame_arbiter
  import mem_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int MAX_WORDS = 1024,
  localparam int PW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int WCW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_PORTS-1:0]                 port_en,
  input  logic [N_PORTS-1:0]                 fifo_empty,
  output logic [N_PORTS-1:0]                 fifo_rd_en,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0] fifo_rd_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_last,
  output logic [PW-1:0]                      out_port,
  output logic                               busy,
  output logic                               trunc_err,
  output logic [15:0]                        frame_cnt
);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [PW-1:0]         r_grant;
  logic [PW-1:0]         r_last_grant;
  logic [WCW-1:0]        r_word_cnt;
  logic [15:0]           r_frame_cnt;
  logic                  r_trunc_err;

  logic [N_PORTS-1:0]    w_eligible;
  logic [N_PORTS-1:0]    w_pick_onehot;
  logic [PW-1:0]         w_pick_idx;
  logic                  w_pick_any;
  logic [N_PORTS-1:0]    w_rd_en;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_trunc;
  logic                  w_last;
  logic                  w_handshake;
  logic                  w_grant_empty;

  // port_en only matters here, so a granted frame survives its port being disabled
  assign w_eligible = port_en & ~fifo_empty;

  rr_picker #(
    .N  (N_PORTS),
    .IW (PW)
  ) u_picker (
    .i_req    (w_eligible),
    .i_last   (r_last_grant),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_word        = fifo_rd_data[r_grant];
  assign w_trunc       = (r_word_cnt == WCW'(MAX_WORDS - 1));
  assign w_last        = w_word[LAST_BIT] | w_trunc;
  assign w_handshake   = (r_state == PRES) && out_ready;
  assign w_grant_empty = fifo_empty[r_grant];

  always_comb begin
    w_next_state = r_state;
    w_rd_en      = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_rd_en      = w_pick_onehot;
          w_next_state = PRES;
        end
      end
      PRES: begin
        if (w_handshake) begin
          if (w_last) begin
            w_next_state = IDLE;
          end else if (!w_grant_empty) begin
            w_rd_en[r_grant] = 1'b1;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (!w_grant_empty) begin
          w_rd_en[r_grant] = 1'b1;
          w_next_state     = PRES;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= PW'(N_PORTS - 1);
      r_word_cnt   <= '0;
      r_frame_cnt  <= '0;
      r_trunc_err  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_trunc_err <= 1'b0;
      if (r_state == IDLE && w_pick_any) begin
        r_grant <= w_pick_idx;
      end
      if (w_handshake) begin
        if (w_last) begin
          r_last_grant <= r_grant;
          r_frame_cnt  <= r_frame_cnt + 16'd1;
          r_word_cnt   <= '0;
          r_trunc_err  <= w_trunc;
        end else begin
          r_word_cnt <= r_word_cnt + 1'b1;
        end
      end
    end
  end

  // Strobes are gated by reset because the IDLE pick is purely combinational
  assign fifo_rd_en = rst_n ? w_rd_en : '0;
  assign out_valid  = (r_state == PRES);
  assign out_data   = out_valid ? w_word : '0;
  assign out_last   = out_valid & w_last;
  assign out_port   = r_grant;
  assign busy       = (r_state != IDLE);
  assign trunc_err  = r_trunc_err;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// Scoreboard bench for ingress_frame_arbiter: behavioural FIFOs feed the DUT and
// a frame-level model predicts grants, words, last markers and truncation.
`timescale 1ns/1ps
module tb_ingress_frame_arbiter;
  import mem_pkg::*;

  localparam int NP = 4;
  localparam int MW = 8;
  localparam int PW = 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  trunc;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NP-1:0]                 port_en;
  logic [NP-1:0]                 fifo_empty;
  logic [NP-1:0]                 fifo_rd_en;
  logic [NP-1:0][DATA_WIDTH-1:0] fifo_rd_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_last;
  logic [PW-1:0]                 out_port;
  logic                          busy;
  logic                          trunc_err;
  logic [15:0]                   frame_cnt;

  ingress_frame_arbiter #(
    .N_PORTS   (NP),
    .MAX_WORDS (MW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_en      (port_en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_port     (out_port),
    .busy         (busy),
    .trunc_err    (trunc_err),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] fifoQ  [NP][$];
  logic [DATA_WIDTH-1:0] staged [NP][$];
  exp_t                  expQ   [NP][$];

  int vectors     = 0;
  int miscompares = 0;
  int readyPct    = 100;
  int stallPct    = 0;
  int enPct       = 100;
  int readyLowCnt = 0;

  bit            mIdle      = 1'b1;
  int            mGrant     = 0;
  int            mLastGrant = NP - 1;
  bit            mValidDue  = 1'b0;
  bit            mTruncDue  = 1'b0;
  bit            mFrameDue  = 1'b0;
  int            mFrames    = 0;
  logic [NP-1:0] mElig;
  int            mPick;
  exp_t          mHead;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rrPick(input logic [NP-1:0] elig, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (elig[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  function automatic bit anyPending();
    for (int p = 0; p < NP; p++) begin
      if (fifoQ[p].size() != 0 || expQ[p].size() != 0 || staged[p].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // A frame's expected words are queued the moment it is generated; truncation
  // splits it every MW words regardless of where the real last word falls.
  task automatic stageFrame(input int p, input int len);
    logic [DATA_WIDTH-1:0] w;
    exp_t e;
    for (int i = 0; i < len; i++) begin
      w           = DATA_WIDTH'($urandom);
      w[LAST_BIT] = (i == len - 1);
      e.data      = w;
      e.trunc     = ((i % MW) == MW - 1);
      e.last      = w[LAST_BIT] | e.trunc;
      staged[p].push_back(w);
      expQ[p].push_back(e);
    end
  endtask

  task automatic releaseWords(input int p, input int n);
    for (int i = 0; i < n && staged[p].size() > 0; i++) fifoQ[p].push_back(staged[p].pop_front());
  endtask

  task automatic pushFrame(input int p, input int len);
    stageFrame(p, len);
    releaseWords(p, len);
  endtask

  task automatic flushAll();
    for (int p = 0; p < NP; p++) begin
      fifoQ[p].delete();
      staged[p].delete();
      expQ[p].delete();
    end
  endtask

  // Behavioural FIFO read side plus random port_en / stall / backpressure.
  task automatic applyStimulus(input logic [NP-1:0] popMask);
    for (int p = 0; p < NP; p++) begin
      if (popMask[p] && fifoQ[p].size() > 0) fifo_rd_data[p] = fifoQ[p].pop_front();
      fifo_empty[p] = (fifoQ[p].size() == 0) || (int'($urandom_range(0, 99)) < stallPct);
      port_en[p]    = int'($urandom_range(0, 99)) < enPct;
    end
    out_ready = (readyLowCnt > 0) ? 1'b0 : (int'($urandom_range(0, 99)) < readyPct);
    if (readyLowCnt > 0) readyLowCnt--;
  endtask

  task automatic waitValid(input string name, input int bound);
    int n = 0;
    while (!out_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: out_valid never rose within %0d cycles", name, bound);
    end
  endtask

  task automatic waitDrain(input string name, input int bound);
    int n = 0;
    while ((anyPending() || !mIdle) && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (n >= bound) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: scoreboard not drained within %0d cycles", name, bound);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin : driver
    logic [NP-1:0] popMask;
    forever begin
      @(negedge clk);
      popMask = fifo_rd_en;
      @(posedge clk);
      #1;
      applyStimulus(popMask);
    end
  end

  // Monitor: the model is IDLE between frames, picks round-robin from the bench's
  // own eligibility view, then pops the granted port's expected words on handshakes.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mIdle      = 1'b1;
        mGrant     = 0;
        mLastGrant = NP - 1;
        mValidDue  = 1'b0;
        mTruncDue  = 1'b0;
        mFrameDue  = 1'b0;
        mFrames    = 0;
      end else begin
        if (mTruncDue || trunc_err) checkOutput("trunc_err", 32'(trunc_err), 32'(mTruncDue));
        mTruncDue = 1'b0;
        if (mFrameDue) checkOutput("frame_cnt", 32'(frame_cnt), 32'(mFrames));
        mFrameDue = 1'b0;
        checkOutput("busy", 32'(busy), 32'(!mIdle));
        if (mValidDue) checkOutput("first_word_latency", 32'(out_valid), 32'd1);
        mValidDue = 1'b0;
        if (mIdle) begin
          mElig = port_en & ~fifo_empty;
          if (mElig != '0) begin
            mPick = rrPick(mElig, mLastGrant);
            checkOutput("idle_grant_strobe", 32'(fifo_rd_en), 32'(1 << mPick));
            mGrant    = mPick;
            mIdle     = 1'b0;
            mValidDue = 1'b1;
          end else if (out_valid || fifo_rd_en != '0) begin
            checkOutput("idle_quiet", 32'({out_valid, fifo_rd_en}), 32'd0);
          end
        end else if (out_valid) begin
          checkOutput("out_port", 32'(out_port), 32'(mGrant));
          if (expQ[mGrant].size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_underflow: word 0x%0h from port %0d not expected", out_data, mGrant);
          end else begin
            mHead = expQ[mGrant][0];
            checkOutput("out_data", 32'(out_data), 32'(mHead.data));
            checkOutput("out_last", 32'(out_last), 32'(mHead.last));
            if (out_ready) begin
              void'(expQ[mGrant].pop_front());
              if (mHead.last) begin
                checkOutput("rd_en_on_last", 32'(fifo_rd_en), 32'd0);
                mIdle      = 1'b1;
                mLastGrant = mGrant;
                mFrames    = (mFrames + 1) % 65536;
                mFrameDue  = 1'b1;
                mTruncDue  = mHead.trunc;
              end else begin
                checkOutput("rd_en_continue", 32'(fifo_rd_en), fifo_empty[mGrant] ? 32'd0 : 32'(1 << mGrant));
              end
            end else begin
              checkOutput("rd_en_stalled", 32'(fifo_rd_en), 32'd0);
            end
          end
        end else begin
          checkOutput("rd_en_wait", 32'(fifo_rd_en), fifo_empty[mGrant] ? 32'd0 : 32'(1 << mGrant));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    rst_n        = 1'b0;
    out_ready    = 1'b0;
    port_en      = '1;
    fifo_empty   = '1;
    fifo_rd_data = '0;

    // Reset state, with port 3 already eligible so the strobe gating is exercised
    repeat (3) @(posedge clk);
    #2;
    pushFrame(3, 2);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("reset_trunc_err", 32'(trunc_err), 32'd0);
    checkOutput("reset_out_port", 32'(out_port), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitDrain("first_frame", 200);

    // Two 3-word frames on ports 0 and 2 at full rate
    pushFrame(0, 3);
    pushFrame(2, 3);
    waitDrain("two_frames", 200);

    // Every port busy with single-word frames: strict rotation
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) pushFrame(p, 1);
    end
    waitDrain("rotation", 200);

    // Backpressure for 5 cycles mid-frame
    pushFrame(1, 6);
    waitValid("stall_start", 30);
    readyLowCnt = 5;
    waitDrain("backpressure", 200);

    // Port 1 runs dry after word 2 of 4 while port 2 waits its turn
    stageFrame(1, 4);
    releaseWords(1, 2);
    waitValid("wait_start", 30);
    pushFrame(2, 3);
    repeat (10) @(posedge clk);
    #2;
    checkOutput("wait_out_valid", 32'(out_valid), 32'd0);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    checkOutput("wait_out_port", 32'(out_port), 32'd1);
    releaseWords(1, 2);
    waitDrain("refill", 200);

    // 10-word frame against an 8-word limit
    pushFrame(0, 10);
    waitDrain("truncation", 200);

    // Randomised traffic
    readyPct = 70;
    stallPct = 20;
    enPct    = 80;
    for (int f = 0; f < 40; f++) begin
      pushFrame(int'($urandom_range(0, NP - 1)), int'($urandom_range(1, 12)));
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #2;
    end
    readyPct = 100;
    stallPct = 0;
    enPct    = 100;
    waitDrain("random", 4000);

    // Reset in the middle of a held frame, then port 0 must win first
    readyPct = 0;
    pushFrame(2, 6);
    waitValid("reset_mid_frame", 30);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("midreset_frame_cnt", 32'(frame_cnt), 32'd0);
    flushAll();
    readyPct = 100;
    pushFrame(3, 2);
    pushFrame(0, 2);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitValid("post_reset_grant", 30);
    checkOutput("post_reset_first_port", 32'(out_port), 32'd0);
    waitDrain("post_reset", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ingress_frame_arbiter.md
INGRESS_FRAME_ARBITER -- requirements
Module: ingress_frame_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of ingress FIFO read sides arbitrated.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, maximum words per frame before forced truncation.
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port port_en  in  N_PORTS  per-port eligibility mask.
REQ-006 SHALL have port fifo_empty  in  N_PORTS  per-port FIFO empty flag.
REQ-007 SHALL have port fifo_rd_en  out  N_PORTS  per-port FIFO read strobe, at most one bit high.
REQ-008 SHALL have port fifo_rd_data  in  N_PORTS x DATA_WIDTH  per-port FIFO read data, valid the cycle after a strobe and held until the next strobe.
REQ-009 SHALL have port out_valid  out  1  egress word valid.
REQ-010 SHALL have port out_ready  in  1  egress backpressure.
REQ-011 SHALL have port out_data  out  DATA_WIDTH  egress word.
REQ-012 SHALL have port out_last  out  1  end-of-frame marker.
REQ-013 SHALL have port out_port  out  clog2(N_PORTS)  source port of current frame.
REQ-014 SHALL have port busy  out  1  high when not in IDLE.
REQ-015 SHALL have port trunc_err  out  1  one-cycle pulse on forced truncation.
REQ-016 SHALL have port frame_cnt  out  16  completed-frame counter, wraps at 2^16.

Function
REQ-017 SHALL implement states IDLE, PRES, WAIT; the frame is the arbitration unit, with no preemption mid-frame.
REQ-018 SHALL, in IDLE: eligible = port_en & ~fifo_empty; if nonzero, pick the first eligible port searching from last_grant+1 upward with wrap, assert that fifo_rd_en combinationally in the same cycle, register grant, go to PRES.
REQ-019 SHALL, in PRES: out_valid=1, out_data=fifo_rd_data[grant], out_port=grant, out_last=out_data[LAST_BIT] OR truncation condition.
REQ-020 SHALL, in PRES without out_ready: hold all outputs stable with no strobe.
REQ-021 SHALL, in PRES on handshake with out_last=1: go to IDLE, set last_grant=grant, increment frame_cnt.
REQ-022 SHALL, in PRES on handshake, not last, fifo_empty[grant]=0: strobe fifo_rd_en[grant] the same cycle and stay in PRES, giving a sustained rate of 1 word/cycle.
REQ-023 SHALL, in PRES on handshake, not last, fifo_empty[grant]=1: go to WAIT.
REQ-024 SHALL, in WAIT: out_valid=0; when fifo_empty[grant]=0, strobe and go to PRES.
REQ-025 SHALL keep word_cnt counting accepted words of the current frame, clearing it on frame end.
REQ-026 SHALL force out_last=1 when word_cnt=MAX_WORDS-1 in PRES, and pulse trunc_err on that handshake; residual words then arbitrate as a new frame.
REQ-027 SHALL apply port_en only in IDLE; deasserting port_en of the granted port mid-frame SHALL not stop that frame.
REQ-028 SHALL never assert fifo_rd_en to a port whose fifo_empty is high.
REQ-029 SHALL use a first-word latency of 1 cycle: fifo_empty falls in cycle t in IDLE -> out_valid in t+1.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force: state=IDLE, last_grant=N_PORTS-1 (port 0 first), grant=0, word_cnt=0, frame_cnt=0, trunc_err=0; out_valid, busy and fifo_rd_en SHALL be 0 while in reset.
REQ-031 SHALL, on reset mid-frame, drop the frame silently, with the remainder arbitrated as a new frame after release.

Structure
REQ-032 SHALL take DATA_WIDTH and LAST_BIT (=DATA_WIDTH-1) from mem_pkg, with the arbiter state enum added to mem_pkg.
REQ-033 SHALL isolate the round-robin search in combinational sub-module rr_picker (inputs: request vector, last_grant; outputs: one-hot, index, any).

Verification
REQ-034 SHALL cover: ports 0,2 each hold a 3-word frame, out_ready=1 -> port 0's words on cycles 1-3, port 2's on cycles 5-7, frame_cnt=2.
REQ-035 SHALL cover: all four ports continuously nonempty with 1-word frames -> grant order 0,1,2,3,0.
REQ-036 SHALL cover: out_ready low 5 cycles mid-frame -> out_data stable, zero fifo_rd_en pulses.
REQ-037 SHALL cover: port 1 empties after word 2 of 4 -> WAIT with out_valid=0; refill -> words 3,4 follow, with no other port granted.
REQ-038 SHALL cover: MAX_WORDS=8, 10-word frame -> word 8 carries out_last=1 with trunc_err pulse; words 9-10 emerge as a separate frame.
REQ-039 SHALL cover: rst_n low mid-frame -> outputs zero immediately; after release port 0 is granted first.
